// File: rtl/axis_ip_dispatcher.sv
// Cuts a pixel-group stream into fixed-size blocks and deals each block
// to an image processor by credit-gated round-robin on tdest.
module axis_ip_dispatcher #(
    parameter int IP_AMT       = 4,
    parameter int IP_ADDR_W    = $clog2(IP_AMT),
    parameter int AXIS_TDEST_W = (IP_ADDR_W > 1) ? IP_ADDR_W : 1,
    parameter int AXIS_TID_W   = 2,
    parameter int AXIS_TID_VAL = 0,
    parameter int AXIS_TDATA_W = 256,
    parameter int BLK_PGROUP   = 8,
    parameter int FRAME_BLK    = 16,
    parameter int IP_CREDIT    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable_i,
    input  logic [AXIS_TDATA_W-1:0]   s_tdata_i,
    input  logic                      s_tvalid_i,
    output logic                      s_tready_o,
    output logic [AXIS_TID_W-1:0]     m_tid_o,
    output logic [AXIS_TDEST_W-1:0]   m_tdest_o,
    output logic [AXIS_TDATA_W-1:0]   m_tdata_o,
    output logic [AXIS_TDATA_W/8-1:0] m_tkeep_o,
    output logic [AXIS_TDATA_W/8-1:0] m_tstrb_o,
    output logic                      m_tlast_o,
    output logic                      m_tvalid_o,
    input  logic                      m_tready_i,
    input  logic [IP_AMT-1:0]         ip_done_i,
    output logic                      frame_busy_o,
    output logic                      frame_done_o,
    output logic                      credit_err_o
);

    localparam int CRED_W = $clog2(IP_CREDIT + 1);
    localparam int BEAT_W = (BLK_PGROUP > 1) ? $clog2(BLK_PGROUP) : 1;
    localparam int BLK_W  = (FRAME_BLK > 1) ? $clog2(FRAME_BLK) : 1;

    localparam logic [CRED_W-1:0] CRED_MAX  = CRED_W'(IP_CREDIT);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BLK_PGROUP - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(FRAME_BLK - 1);

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        STREAM
    } state_t;

    state_t                  state;
    logic [AXIS_TDEST_W-1:0] rr_ptr;
    logic [AXIS_TDEST_W-1:0] dest;
    logic [BEAT_W-1:0]       beat_cnt;
    logic [BLK_W-1:0]        blk_cnt;
    logic [CRED_W-1:0]       credit [IP_AMT];

    logic                    grant_v;
    logic [AXIS_TDEST_W-1:0] grant_idx;
    logic [AXIS_TDEST_W-1:0] cand;
    logic                    take;
    logic                    up_acc;
    logic                    blk_end;

    assign m_tid_o   = AXIS_TID_W'(AXIS_TID_VAL);
    assign m_tkeep_o = '1;
    assign m_tstrb_o = '1;

    // One-deep output slice: take a new beat whenever it is empty or draining.
    assign s_tready_o = (state == STREAM) & (~m_tvalid_o | m_tready_i);
    assign up_acc     = s_tvalid_i & s_tready_o;
    assign blk_end    = up_acc & (beat_cnt == BEAT_LAST);
    assign take       = (state == SELECT) & grant_v;

    // Walk downwards so the candidate nearest rr_ptr wins.
    always_comb begin
        grant_v   = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = IP_AMT - 1; i >= 0; i--) begin
            cand = AXIS_TDEST_W'((int'(rr_ptr) + i) % IP_AMT);
            if (credit[cand] != '0) begin
                grant_v   = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < IP_AMT; k++) begin
                credit[k] <= CRED_MAX;
            end
            credit_err_o <= 1'b0;
        end else begin
            // Same-cycle grant and done on one index cancel out.
            for (int k = 0; k < IP_AMT; k++) begin
                if (ip_done_i[k] && !(take && int'(grant_idx) == k)) begin
                    if (credit[k] == CRED_MAX) begin
                        credit_err_o <= 1'b1;
                    end else begin
                        credit[k] <= credit[k] + 1'b1;
                    end
                end else if (!ip_done_i[k] && take && int'(grant_idx) == k) begin
                    credit[k] <= credit[k] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            dest         <= '0;
            beat_cnt     <= '0;
            blk_cnt      <= '0;
            m_tvalid_o   <= 1'b0;
            m_tlast_o    <= 1'b0;
            m_tdest_o    <= '0;
            m_tdata_o    <= '0;
            frame_busy_o <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;

            if (up_acc) begin
                m_tdata_o  <= s_tdata_i;
                m_tdest_o  <= dest;
                m_tlast_o  <= (beat_cnt == BEAT_LAST);
                m_tvalid_o <= 1'b1;
            end else if (m_tready_i) begin
                m_tvalid_o <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (enable_i) begin
                        state        <= SELECT;
                        frame_busy_o <= 1'b1;
                    end
                end
                SELECT: begin
                    if (grant_v) begin
                        dest   <= grant_idx;
                        rr_ptr <= (int'(grant_idx) == IP_AMT - 1) ?
                                  '0 : grant_idx + 1'b1;
                        state  <= STREAM;
                    end
                end
                STREAM: begin
                    if (blk_end) begin
                        beat_cnt <= '0;
                        if (blk_cnt != BLK_LAST) begin
                            blk_cnt <= blk_cnt + 1'b1;
                            state   <= SELECT;
                        end else begin
                            blk_cnt      <= '0;
                            frame_done_o <= 1'b1;
                            frame_busy_o <= enable_i;
                            state        <= enable_i ? SELECT : IDLE;
                        end
                    end else if (up_acc) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_ip_dispatcher.sv
// Randomised scoreboard bench for axis_ip_dispatcher against a
// block/credit level reference model.
module tb_axis_ip_dispatcher;

    localparam int IP_AMT = 4;
    localparam int DW     = 256;
    localparam int KW     = DW / 8;
    localparam int TDW    = 2;
    localparam int BLK    = 8;
    localparam int FBLK   = 16;
    localparam int CRED   = 2;

    localparam int P_IDLE = 0;
    localparam int P_SEL  = 1;
    localparam int P_STR  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable_i = 1'b0;
    logic [DW-1:0]     s_tdata_i = '0;
    logic              s_tvalid_i = 1'b0;
    logic              s_tready_o;
    logic [1:0]        m_tid_o;
    logic [TDW-1:0]    m_tdest_o;
    logic [DW-1:0]     m_tdata_o;
    logic [KW-1:0]     m_tkeep_o;
    logic [KW-1:0]     m_tstrb_o;
    logic              m_tlast_o;
    logic              m_tvalid_o;
    logic              m_tready_i = 1'b0;
    logic [IP_AMT-1:0] ip_done_i = '0;
    logic              frame_busy_o;
    logic              frame_done_o;
    logic              credit_err_o;

    axis_ip_dispatcher dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable_i),
        .s_tdata_i    (s_tdata_i),
        .s_tvalid_i   (s_tvalid_i),
        .s_tready_o   (s_tready_o),
        .m_tid_o      (m_tid_o),
        .m_tdest_o    (m_tdest_o),
        .m_tdata_o    (m_tdata_o),
        .m_tkeep_o    (m_tkeep_o),
        .m_tstrb_o    (m_tstrb_o),
        .m_tlast_o    (m_tlast_o),
        .m_tvalid_o   (m_tvalid_o),
        .m_tready_i   (m_tready_i),
        .ip_done_i    (ip_done_i),
        .frame_busy_o (frame_busy_o),
        .frame_done_o (frame_done_o),
        .credit_err_o (credit_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            dest;
        bit            last;
    } exp_t;

    exp_t sbq[$];
    exp_t ev;

    int n_checks = 0;
    int n_fail   = 0;

    // control knobs written by the sequencer only
    int                p_valid = 0;
    int                p_ready = 100;
    bit                auto_done = 0;
    logic [IP_AMT-1:0] man_done = '0;

    // reference model state
    int  ph, rr, cur_dest, beat, blk, nc;
    int  cred [IP_AMT];
    bit  mv, e_busy, e_fdone, e_err, exp_rdy, acc, g_ok;
    int  g_idx;
    bit  hold_v;
    logic [DW-1:0]  hold_d;
    logic [TDW-1:0] hold_t;
    bit  up_acc;
    logic [IP_AMT-1:0] pend_done;
    int  acc_beats, out_beats, blocks_out, frames;
    int  last_dest, first_dest;
    bit  seen_first;

    task automatic check(input string nm, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int cur_val(input int sel);
        case (sel)
            0:       return blocks_out;
            1:       return frames;
            default: return acc_beats;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int target,
                            input int budget, input string nm);
        int n = 0;
        while (cur_val(sel) < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (cur_val(sel) < target) begin
            n_fail++;
            $display("FAIL %s: timeout, value %0d below target %0d",
                     nm, cur_val(sel), target);
        end
    endtask

    // input driver, updates just after the falling edge
    always @(negedge clk) begin
        #1;
        if (!s_tvalid_i || up_acc) begin
            s_tvalid_i = ($urandom_range(99) < p_valid);
            for (int w = 0; w < DW / 32; w++) begin
                s_tdata_i[w*32 +: 32] = $urandom;
            end
        end
        m_tready_i = ($urandom_range(99) < p_ready);
        ip_done_i  = (auto_done ? pend_done : '0) | man_done;
    end

    // monitor + reference model, evaluated on pre-edge values
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = P_IDLE; rr = 0; cur_dest = 0; beat = 0; blk = 0;
            for (int k = 0; k < IP_AMT; k++) cred[k] = CRED;
            mv = 0; e_busy = 0; e_fdone = 0; e_err = 0;
            sbq.delete();
            hold_v = 0; up_acc = 0; pend_done = '0;
            acc_beats = 0; seen_first = 0;
        end else begin
            exp_rdy = (ph == P_STR) && (!mv || m_tready_i);
            check("s_tready", s_tready_o, exp_rdy);
            check("frame_busy", frame_busy_o, e_busy);
            check("frame_done", frame_done_o, e_fdone);
            check("credit_err", credit_err_o, e_err);
            check("tid", m_tid_o, 0);

            if (hold_v) begin
                check("hold_valid", m_tvalid_o, 1);
                check("hold_data", m_tdata_o, hold_d);
                check("hold_dest", m_tdest_o, hold_t);
            end

            pend_done = '0;
            if (m_tvalid_o && m_tready_i) begin
                check("beat_expected", sbq.size() != 0, 1);
                if (sbq.size() != 0) begin
                    ev = sbq.pop_front();
                    check("out_data", m_tdata_o, ev.d);
                    check("out_dest", m_tdest_o, ev.dest);
                    check("out_last", m_tlast_o, ev.last);
                end
                if (!seen_first) begin
                    seen_first = 1;
                    first_dest = m_tdest_o;
                end
                out_beats++;
                if (m_tlast_o) begin
                    blocks_out++;
                    last_dest = m_tdest_o;
                    pend_done[m_tdest_o] = 1'b1;
                end
            end
            hold_v = m_tvalid_o && !m_tready_i;
            hold_d = m_tdata_o;
            hold_t = m_tdest_o;
            up_acc = s_tvalid_i && s_tready_o;

            acc   = s_tvalid_i && exp_rdy;
            g_ok  = 0;
            g_idx = 0;
            if (ph == P_SEL) begin
                for (int i = 0; i < IP_AMT; i++) begin
                    if (!g_ok && cred[(rr + i) % IP_AMT] > 0) begin
                        g_ok  = 1;
                        g_idx = (rr + i) % IP_AMT;
                    end
                end
            end
            for (int k = 0; k < IP_AMT; k++) begin
                nc = cred[k] + int'(ip_done_i[k])
                     - ((g_ok && g_idx == k) ? 1 : 0);
                if (nc > CRED) begin
                    e_err = 1;
                    nc = CRED;
                end
                cred[k] = nc;
            end

            if (acc) begin
                ev.d    = s_tdata_i;
                ev.dest = cur_dest;
                ev.last = (beat == BLK - 1);
                sbq.push_back(ev);
                mv = 1;
                acc_beats++;
            end else if (m_tready_i) begin
                mv = 0;
            end

            e_fdone = 0;
            case (ph)
                P_IDLE: if (enable_i) begin
                    ph = P_SEL;
                    e_busy = 1;
                end
                P_SEL: if (g_ok) begin
                    ph = P_STR;
                    cur_dest = g_idx;
                    rr = (g_idx + 1) % IP_AMT;
                end
                default: if (acc) begin
                    beat++;
                    if (beat == BLK) begin
                        beat = 0;
                        blk++;
                        if (blk == FBLK) begin
                            blk = 0;
                            e_fdone = 1;
                            frames++;
                            e_busy = enable_i;
                            ph = enable_i ? P_SEL : P_IDLE;
                        end else begin
                            ph = P_SEL;
                        end
                    end
                end
            endcase
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int b0, f0, o0;

    initial begin
        out_beats = 0; blocks_out = 0; frames = 0;
        last_dest = -1; first_dest = -1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_tvalid", m_tvalid_o, 0);
        check("rst_tready", s_tready_o, 0);
        check("rst_tlast", m_tlast_o, 0);
        check("rst_tdest", m_tdest_o, 0);
        check("rst_tdata", m_tdata_o, 0);
        check("rst_busy", frame_busy_o, 0);
        check("rst_done", frame_done_o, 0);
        check("rst_err", credit_err_o, 0);
        check("rst_tid", m_tid_o, 0);
        check("rst_tkeep", m_tkeep_o, {KW{1'b1}});
        check("rst_tstrb", m_tstrb_o, {KW{1'b1}});
        @(negedge clk);
        rst_n = 1;

        // full-rate frame, grant+done collide on index 0 at the first grant
        p_valid = 100; p_ready = 100; auto_done = 1;
        repeat (2) @(negedge clk);
        b0 = blocks_out; f0 = frames; o0 = out_beats;
        enable_i = 1;
        @(negedge clk);
        man_done = 4'b0001;
        @(negedge clk);
        man_done = '0;
        check("same_cycle_no_err", credit_err_o, 0);
        wait_for(0, b0 + 5, 400, "reach_block5");
        enable_i = 0;
        wait_for(1, f0 + 1, 1000, "frame1_end");
        repeat (5) @(negedge clk);
        check("frame1_count", frames - f0, 1);
        check("frame1_blocks", blocks_out - b0, FBLK);
        check("frame1_beats", out_beats - o0, FBLK * BLK);
        check("frame1_idle_tready", s_tready_o, 0);
        check("frame1_idle_busy", frame_busy_o, 0);

        // no credits returned: stall after one round of credits
        auto_done = 0;
        b0 = blocks_out; f0 = frames;
        enable_i = 1;
        wait_for(0, b0 + IP_AMT * CRED, 400, "stall_fill");
        repeat (20) @(negedge clk);
        check("stall_blocks", blocks_out - b0, IP_AMT * CRED);
        check("stall_tready", s_tready_o, 0);
        check("stall_busy", frame_busy_o, 1);
        enable_i = 0;
        man_done = 4'b0100;
        @(negedge clk);
        man_done = '0;
        wait_for(0, b0 + IP_AMT * CRED + 1, 100, "after_done2");
        check("after_done2_dest", last_dest, 2);
        repeat (2) begin
            man_done = 4'b1111;
            @(negedge clk);
            man_done = '0;
            repeat (30) @(negedge clk);
        end
        wait_for(1, f0 + 1, 500, "stall_frame_end");
        repeat (5) @(negedge clk);
        check("stall_frame_tready", s_tready_o, 0);

        // credit overflow, then random traffic on both sides
        rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        man_done = 4'b0010;
        @(negedge clk);
        man_done = '0;
        @(negedge clk);
        check("credit_err_set", credit_err_o, 1);
        p_valid = 70; p_ready = 50; auto_done = 1;
        f0 = frames;
        enable_i = 1;
        wait_for(1, f0 + 2, 4000, "rand_two_frames");
        enable_i = 0;
        wait_for(1, f0 + 3, 2500, "rand_last_frame");
        repeat (10) @(negedge clk);
        check("credit_err_sticky", credit_err_o, 1);
        check("rand_drained", sbq.size(), 0);
        check("rand_idle_tready", s_tready_o, 0);

        // asynchronous reset in the middle of block 2
        p_valid = 100; p_ready = 100;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        enable_i = 1;
        wait_for(2, 2 * BLK + 4, 200, "reach_blk2_beat3");
        #2;
        rst_n = 0;
        #1;
        check("async_tvalid", m_tvalid_o, 0);
        check("async_tready", s_tready_o, 0);
        check("async_busy", frame_busy_o, 0);
        check("async_tdata", m_tdata_o, 0);
        check("async_tdest", m_tdest_o, 0);
        check("async_tlast", m_tlast_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        b0 = blocks_out; f0 = frames;
        wait_for(0, b0 + 1, 100, "post_reset_block");
        check("post_reset_dest", first_dest, 0);
        enable_i = 0;
        wait_for(1, f0 + 1, 1000, "post_reset_frame");
        repeat (5) @(negedge clk);
        check("post_reset_blocks", blocks_out - b0, FBLK);
        check("post_reset_err", credit_err_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_ip_dispatcher.md
Name: axis_ip_dispatcher

Overview:
- Upstream scheduler for the image-processor stream controller.
- Takes an untagged pixel-group stream from frame fetch and cuts it into fixed-size blocks.
- Assigns each block to one image processor by credit-gated round-robin.
- Emits an AXI-Stream with tdest set to the granted processor and tlast on the final beat of each block. Also tracks frame boundaries.

Parameters:
- IP_AMT, 4, number of image processors.
- IP_ADDR_W, $clog2(IP_AMT), processor index width.
- AXIS_TDEST_W, (IP_ADDR_W>1)?IP_ADDR_W:1, tdest width.
- AXIS_TID_W, 2, tid width.
- AXIS_TID_VAL, 0, constant tid driven on every beat.
- AXIS_TDATA_W, 256, pixel-group width.
- BLK_PGROUP, 8, pixel groups per block (>=1).
- FRAME_BLK, 16, blocks per frame (>=1).
- IP_CREDIT, 2, maximum outstanding blocks per processor (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- enable_i  in  1  run enable, sampled at frame boundaries.
- s_tdata_i  in  AXIS_TDATA_W  upstream pixel group.
- s_tvalid_i  in  1  upstream valid.
- s_tready_o  out  1  upstream ready.
- m_tid_o  out  AXIS_TID_W  stream id.
- m_tdest_o  out  AXIS_TDEST_W  granted processor index.
- m_tdata_o  out  AXIS_TDATA_W  pixel group.
- m_tkeep_o  out  AXIS_TDATA_W/8  all ones.
- m_tstrb_o  out  AXIS_TDATA_W/8  all ones.
- m_tlast_o  out  1  last beat of block.
- m_tvalid_o  out  1  downstream valid.
- m_tready_i  in  1  downstream ready.
- ip_done_i  in  IP_AMT  one-cycle pulse per processor, returns one credit.
- frame_busy_o  out  1  high while a frame is in progress.
- frame_done_o  out  1  one-cycle pulse at frame end.
- credit_err_o  out  1  sticky credit-overflow flag.

Behaviour:
- Reset is asynchronous on rst_n low:
  - FSM=IDLE; rr_ptr=0; beat/block counters=0.
  - All credit counters=IP_CREDIT.
  - m_tvalid_o=0, m_tlast_o=0, m_tdest_o=0, m_tdata_o=0.
  - s_tready_o=0, frame_busy_o=0, frame_done_o=0, credit_err_o=0.
  - m_tid_o=AXIS_TID_VAL; m_tkeep_o/m_tstrb_o all ones (constants).
- FSM states IDLE, SELECT, STREAM.
- IDLE:
  - s_tready_o=0.
  - enable_i=1 -> SELECT next cycle; frame_busy_o=1 from that edge.
- SELECT (one decision per cycle):
  - Grant the first index, searching rr_ptr, rr_ptr+1, ... modulo IP_AMT, whose credit>0.
  - On grant: latch dest=index; credit[index]-=1; rr_ptr=index+1 (wraps IP_AMT-1 -> 0); -> STREAM.
  - No credit anywhere -> stay in SELECT. Minimum grant latency is 1 cycle.
- STREAM:
  - Single registered output slice: s_tready_o = (~m_tvalid_o | m_tready_i).
  - Upstream beat accepted (s_tvalid_i & s_tready_o): load m_tdata_o, m_tdest_o=dest; m_tvalid_o=1 next cycle.
  - m_tlast_o=1 iff beat count==BLK_PGROUP-1. Then beat count++.
  - Downstream accept without a new upstream beat -> m_tvalid_o=0.
  - Data order is preserved; no beat is dropped or duplicated under any m_tready_i pattern.
  - Output latency is 1 cycle from upstream accept.
- Block end (last beat accepted upstream):
  - Beat count=0; block count++.
  - Block count < FRAME_BLK-1 -> SELECT.
  - Else: block count=0; frame_done_o pulses in the next cycle; frame_busy_o falls.
    - enable_i=1 -> SELECT (new frame, frame_busy_o remains high).
    - enable_i=0 -> IDLE.
  - The final beat may still be held in the output slice; it drains normally while the FSM is in SELECT or IDLE.
- enable_i deassertion mid-frame has no effect until the frame completes.
- Credits:
  - Counter width $clog2(IP_CREDIT+1).
  - ip_done_i[k] increments credit[k].
  - Grant and done on the same index in the same cycle -> net unchanged.
  - Done while credit[k]==IP_CREDIT (and no same-cycle grant) -> counter saturates; credit_err_o set, cleared only by reset.
  - Multiple ip_done_i bits may be high simultaneously.
- IP_AMT==1: m_tdest_o is always 0; round-robin degenerates to credit gating.
- Reset mid-block: all state is discarded immediately; no partial block completion.

Test Plan:
- IP_AMT=4, IP_CREDIT=2, m_tready_i=1, ip_done_i pulsed one cycle after each tlast: 1 frame (128 beats) -> tdest sequence 0,1,2,3,0,... per 8-beat block; tlast on beats 7,15,...; one frame_done_o pulse; data equals input.
- No ip_done_i ever: 9th block request stalls in SELECT; s_tready_o=0 after 8 blocks. Then pulse ip_done_i[2] -> next block goes to dest 2.
- m_tready_i random 50%, s_tvalid_i random: scoreboard confirms no loss/duplication; m_tdata_o/m_tdest_o held stable while m_tvalid_o & ~m_tready_i.
- ip_done_i[1] pulsed while credit[1]=2 -> credit_err_o=1, stays 1; same-cycle grant+done on index 0 -> credit unchanged.
- enable_i dropped at block 5 -> frame runs to 16 blocks, frame_done_o pulses, FSM returns to IDLE, s_tready_o=0.
- rst_n asserted at beat 3 of block 2 -> all outputs reset asynchronously; after release and enable, the first block goes to dest 0 with full credits.
